// File: rtl/tft_spi_rx.sv
// tft_spi_rx: receiving end of the 3-wire TFT SPI link (CS/SCL/SDA).
// Oversamples the asynchronous SPI lines on clk and deserialises SPI mode 0
// words, most significant bit first. Words go into a small show-ahead FIFO.
// Frame-done and frame-error pulses report how each CS-low frame ended.
module tft_spi_rx #(
    parameter int DATA_BITS  = 8,   // bits per word (4..16)
    parameter int FIFO_DEPTH = 4    // receive FIFO entries, power of two (2..16)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lcd_cs_i,
    input  logic                 lcd_scl_i,
    input  logic                 lcd_sda_i,
    input  logic                 rd_en_i,
    input  logic                 clr_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 frame_done_o,
    output logic                 frame_err_o,
    output logic                 overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // Synchronisers and edge-detect stages
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_scl_s1, r_scl_s2, r_scl_s3;
    logic r_sda_s1, r_sda_s2;

    // Receiver state
    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-2:0] r_shreg, w_shreg_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_push;
    logic [DATA_BITS-1:0] w_push_data;

    // FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic                 r_overflow;
    logic                 w_pop, w_write, w_drop;

    logic w_cs_fall, w_cs_rise, w_scl_rise;

    // Two-flop synchronisers; preset to the idle bus levels (CS high, SCL/SDA low)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_s1  <= 1'b1;
            r_cs_s2  <= 1'b1;
            r_cs_s3  <= 1'b1;
            r_scl_s1 <= 1'b0;
            r_scl_s2 <= 1'b0;
            r_scl_s3 <= 1'b0;
            r_sda_s1 <= 1'b0;
            r_sda_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each stage takes the previous
            // stage's old value; blocking here would collapse the chain into one flop.
            r_cs_s1  <= lcd_cs_i;
            r_cs_s2  <= r_cs_s1;
            r_cs_s3  <= r_cs_s2;
            r_scl_s1 <= lcd_scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_s3 <= r_scl_s2;
            r_sda_s1 <= lcd_sda_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

    assign w_cs_fall  = r_cs_s3 & ~r_cs_s2;
    assign w_cs_rise  = ~r_cs_s3 & r_cs_s2;
    assign w_scl_rise = ~r_scl_s3 & r_scl_s2;

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Receiver next state: frame start/end, bit shifting and word push
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_push        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_shreg_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                // CS rise takes priority over an SCL rise in the same cycle
                if (w_cs_rise) begin
                    w_state_nxt   = ST_IDLE;
                    w_done_nxt    = (r_bit_cnt == '0);
                    w_err_nxt     = (r_bit_cnt != '0);
                    w_bit_cnt_nxt = '0;
                end else if (w_scl_rise) begin
                    w_shreg_nxt = {r_shreg[DATA_BITS-3:0], r_sda_s2};
                    if (r_bit_cnt == LAST_BIT) begin
                        w_push        = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The final bit joins the word directly from the synchroniser
    assign w_push_data = {r_shreg, r_sda_s2};

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = rd_en_i & ~empty_o;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_write = w_push & (~full_o | w_pop);
    assign w_drop  = w_push & full_o & ~w_pop;

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_drop)     r_overflow <= 1'b1;
            else if (clr_i) r_overflow <= 1'b0;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers define which
        // entries are valid, and data_o is forced to zero while empty.
        if (w_write) r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
    end

    assign data_o       = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign frame_done_o = r_done;
    assign frame_err_o  = r_err;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_tft_spi_rx.sv
// Testbench for tft_spi_rx: drives SPI frames and checks the outputs
// against a queue model of the receive FIFO plus hand-computed values.
module tb_tft_spi_rx;

    localparam int DB   = 8;
    localparam int FD   = 4;
    localparam int HALF = 3;   // SCL half period in clk cycles

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cs = 1'b1, scl = 1'b0, sda = 1'b0;
    logic          rd_en = 1'b0, clr = 1'b0;
    logic [DB-1:0] data_o;
    logic          empty_o, full_o, frame_done_o, frame_err_o, overflow_o;

    tft_spi_rx #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_cs_i     (cs),
        .lcd_scl_i    (scl),
        .lcd_sda_i    (sda),
        .rd_en_i      (rd_en),
        .clr_i        (clr),
        .data_o       (data_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .frame_done_o (frame_done_o),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0;
    logic [DB-1:0] mq[$];   // model FIFO contents, head at index 0
    bit m_ovf = 1'b0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(input logic [DB-1:0] w);
        if (mq.size() == FD) m_ovf = 1'b1;
        else mq.push_back(w);
    endfunction

    function automatic void m_pop();
        logic [DB-1:0] d;
        if (mq.size() > 0) d = mq.pop_front();
    endfunction

    // Count completion pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done_o) done_cnt++;
            if (frame_err_o)  err_cnt++;
        end
    end

    // Per-cycle comparison against the model while the bus is quiet
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("empty", empty_o, mq.size() == 0);
            check("full", full_o, mq.size() == FD);
            check("overflow", overflow_o, m_ovf);
            if (mq.size() > 0) check("head", data_o, mq[0]);
            check("done_quiet", frame_done_o, 1'b0);
            check("err_quiet", frame_err_o, 1'b0);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin();
        cmp_en = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        wait_n(HALF);
    endtask

    task automatic frame_end();
        wait_n(HALF);
        cs = 1'b1;
        wait_n(6);
    endtask

    // Shift nbits of w MSB first; pop_last pops on the cycle the word is pushed
    task automatic send_bits(input logic [15:0] w, input int nbits, input bit pop_last);
        for (int i = nbits - 1; i >= 0; i--) begin
            sda = w[i];
            wait_n(HALF);
            scl = 1'b1;
            if (pop_last && i == 0) begin
                fork
                    begin
                        @(posedge clk);
                        @(posedge clk);
                        #1 rd_en = 1'b1;
                        @(posedge clk);
                        m_pop();
                        #1 rd_en = 1'b0;
                    end
                join_none
            end
            wait_n(HALF);
            scl = 1'b0;
        end
    endtask

    task automatic pop_check(input string name, input logic [DB-1:0] exp);
        @(negedge clk);
        check(name, data_o, exp);
        rd_en = 1'b1;
        @(posedge clk);
        m_pop();
        #1 rd_en = 1'b0;
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        m_ovf = 1'b0;
        #1 clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, empty_o, 1'b1);
        check({tag, "_full"}, full_o, 1'b0);
        check({tag, "_data"}, data_o, 8'h00);
        check({tag, "_ovf"}, overflow_o, 1'b0);
        check({tag, "_done"}, frame_done_o, 1'b0);
        check({tag, "_err"}, frame_err_o, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] words [5];

        // Reset
        #3 rst_n = 1'b0;
        wait_n(2);
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        wait_n(3);

        // 1: single word 0xAA
        frame_begin();
        send_bits(16'h00AA, 8, 1'b0);
        frame_end();
        m_push(8'hAA);
        cmp_en = 1'b1;
        @(negedge clk);
        check("t1_data", data_o, 8'hAA);
        check("t1_empty", empty_o, 1'b0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);
        pop_check("t1_pop", 8'hAA);

        // 2: three back-to-back words in one frame
        frame_begin();
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
        for (int k = 0; k < 3; k++) send_bits({8'h00, words[k]}, 8, 1'b0);
        frame_end();
        for (int k = 0; k < 3; k++) m_push(words[k]);
        cmp_en = 1'b1;
        check("t2_done_cnt", done_cnt, 2);
        pop_check("t2_pop0", 8'h12);
        pop_check("t2_pop1", 8'h34);
        pop_check("t2_pop2", 8'h56);
        @(negedge clk);
        check("t2_empty", empty_o, 1'b1);

        // 3: aborted 5-bit frame, then a clean 0x5A
        frame_begin();
        send_bits(16'h0015, 5, 1'b0);
        frame_end();
        cmp_en = 1'b1;
        @(negedge clk);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_done_cnt", done_cnt, 2);
        check("t3_empty", empty_o, 1'b1);
        frame_begin();
        send_bits(16'h005A, 8, 1'b0);
        frame_end();
        m_push(8'h5A);
        cmp_en = 1'b1;
        check("t3_done_cnt2", done_cnt, 3);
        pop_check("t3_pop", 8'h5A);

        // 4: five words into a 4-deep FIFO
        frame_begin();
        for (int k = 1; k <= 5; k++) send_bits(16'(k), 8, 1'b0);
        frame_end();
        for (int k = 1; k <= 5; k++) m_push(8'(k));
        cmp_en = 1'b1;
        @(negedge clk);
        check("t4_full", full_o, 1'b1);
        check("t4_ovf", overflow_o, 1'b1);
        pop_check("t4_pop1", 8'h01);
        pop_check("t4_pop2", 8'h02);
        pop_check("t4_pop3", 8'h03);
        pop_check("t4_pop4", 8'h04);
        check("t4_ovf_sticky", overflow_o, 1'b1);
        clear_ovf();
        @(negedge clk);
        check("t4_ovf_clr", overflow_o, 1'b0);

        // 5: pop on the same cycle 0x77 lands in a full FIFO
        frame_begin();
        for (int k = 0; k < 4; k++) send_bits(16'(8'h71 + k), 8, 1'b0);
        frame_end();
        for (int k = 0; k < 4; k++) m_push(8'(8'h71 + k));
        cmp_en = 1'b1;
        @(negedge clk);
        check("t5_full_pre", full_o, 1'b1);
        frame_begin();
        send_bits(16'h0077, 8, 1'b1);
        frame_end();
        m_push(8'h77);
        cmp_en = 1'b1;
        @(negedge clk);
        check("t5_ovf", overflow_o, 1'b0);
        check("t5_full", full_o, 1'b1);
        pop_check("t5_pop0", 8'h72);
        pop_check("t5_pop1", 8'h73);
        pop_check("t5_pop2", 8'h74);
        pop_check("t5_pop3", 8'h77);

        // 6: reset mid-word with a stored word, then 0xC3
        frame_begin();
        send_bits(16'h0099, 8, 1'b0);
        send_bits(16'h0005, 3, 1'b0);
        @(negedge clk);
        check("t6_pre_empty", empty_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        cs = 1'b1;
        wait_n(3);
        check_reset_vals("t6_rst_hold");
        rst_n = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        wait_n(3);
        cmp_en = 1'b1;
        wait_n(2);
        frame_begin();
        send_bits(16'h00C3, 8, 1'b0);
        frame_end();
        m_push(8'hC3);
        cmp_en = 1'b1;
        check("t6_done_cnt", done_cnt, 7);
        check("t6_err_cnt", err_cnt, 1);
        pop_check("t6_pop", 8'hC3);
        @(negedge clk);
        check("t6_empty", empty_o, 1'b1);

        wait_n(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
